// File: rtl/proc_input_pkg.sv
// Shared types for the processor input path: action ids and the
// command-controller state encoding.
package proc_input_pkg;

  localparam int N_ACOES = 6;

  typedef logic [$clog2(N_ACOES)-1:0] acao_id_t;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    ISSUE
  } ctrl_state_t;

endpackage

// File: rtl/action_controller_if.sv
// Command handshake from the action controller to the processor's command
// decoder. The controller is the master and offers commands.
interface action_controller_if
  import proc_input_pkg::*;
#(
  parameter int N_ACOES = proc_input_pkg::N_ACOES
);
  localparam int ID_W = (N_ACOES > 1) ? $clog2(N_ACOES) : 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [ID_W-1:0] cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/action_controller_debouncer.sv
// Per-button debouncer: the level follows the raw input only after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; press is a one-cycle rise.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
        level <= raw;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = level & ~level_d;
endmodule

// File: rtl/action_controller.sv
// Debounces the action and enter buttons, arbitrates pending presses and issues
// the confirmed action over a valid/ready handshake. Define ROUND_ROBIN_EN for
// round-robin grant; otherwise the lowest pending index wins.
module action_controller
  import proc_input_pkg::*;
#(
  parameter int N_ACOES         = proc_input_pkg::N_ACOES,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enter_sync,
  input  logic [0:N_ACOES-1]                acoes_sync,
  action_controller_if.master               cmd,
  output logic                              sel_valid,
  output logic [((N_ACOES > 1) ? $clog2(N_ACOES) : 1)-1:0] sel_id,
  output logic [N_ACOES-1:0]                pending
);
  localparam int ID_W = (N_ACOES > 1) ? $clog2(N_ACOES) : 1;

  ctrl_state_t         state;
  logic                cmd_valid_q;
  logic [ID_W-1:0]     cmd_id_q;
  logic                enter_press;
  logic [N_ACOES-1:0]  act_press;
  logic [N_ACOES-1:0]  clr_mask;
  logic [ID_W-1:0]     grant;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk   (clk),
    .reset (reset),
    .raw   (enter_sync),
    .level (),
    .press (enter_press)
  );

  for (genvar i = 0; i < N_ACOES; i++) begin : g_deb
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (acoes_sync[i]),
      .level (),
      .press (act_press[i])
    );
  end

`ifdef ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr;

  function automatic logic [ID_W-1:0] pick_grant(input logic [N_ACOES-1:0] req,
                                                 input logic [ID_W-1:0]    ptr);
    logic        found;
    int unsigned idx;
    pick_grant = '0;
    found      = 1'b0;
    for (int unsigned k = 0; k < N_ACOES; k++) begin
      idx = (ptr + k) % N_ACOES;
      if (!found && req[idx]) begin
        pick_grant = ID_W'(idx);
        found      = 1'b1;
      end
    end
  endfunction

  assign grant = pick_grant(pending, rr_ptr);
`else
  function automatic logic [ID_W-1:0] pick_grant(input logic [N_ACOES-1:0] req);
    pick_grant = '0;
    // Descending scan so the lowest set index is written last.
    for (int unsigned k = N_ACOES; k > 0; k--) begin
      if (req[k-1]) pick_grant = ID_W'(k - 1);
    end
  endfunction

  assign grant = pick_grant(pending);
`endif

  // Confirming clears the selected bit; it overrides a coincident re-press.
  always_comb begin
    clr_mask = '0;
    if (state == SELECT && enter_press) clr_mask[sel_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      sel_valid   <= 1'b0;
      sel_id      <= '0;
      pending     <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      pending <= (pending | act_press) & ~clr_mask;
      case (state)
        IDLE: begin
          if (|pending) begin
            sel_id    <= grant;
            sel_valid <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (enter_press) begin
            cmd_id_q    <= sel_id;
            cmd_valid_q <= 1'b1;
            sel_valid   <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_valid_q && cmd.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state       <= IDLE;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= (cmd_id_q == ID_W'(N_ACOES - 1)) ? '0 : cmd_id_q + ID_W'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.cmd_id    = cmd_id_q;
endmodule

// File: tb/tb_action_controller.sv
// Directed bench for action_controller with DEBOUNCE_CYCLES=4; issued commands
// are checked against a queue of expected action ids.
module tb_action_controller;
  import proc_input_pkg::*;

  localparam int D = 4;
  localparam int N = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         enter_sync;
  logic [0:N-1] acoes_sync;
  logic         sel_valid;
  acao_id_t     sel_id;
  logic [N-1:0] pending;

  action_controller_if #(.N_ACOES(N)) cmd ();

  action_controller #(.N_ACOES(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .enter_sync (enter_sync),
    .acoes_sync (acoes_sync),
    .cmd        (cmd),
    .sel_valid  (sel_valid),
    .sel_id     (sel_id),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int       checks   = 0;
  int       failures = 0;
  int       issued   = 0;
  acao_id_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_sel(input int exp);
    for (int i = 0; i < 20 && sel_valid !== 1'b1; i++) tick();
    chk("sel_valid_wait", 32'(sel_valid), 1);
    chk("sel_id", 32'(sel_id), exp);
  endtask

  // Press enter until the command is offered, then release it long enough
  // for the debounced enter level to return low.
  task automatic confirm(input int exp);
    exp_q.push_back(acao_id_t'(exp));
    enter_sync = 1'b1;
    for (int i = 0; i < 12 && cmd.cmd_valid !== 1'b1; i++) tick();
    chk("cmd_valid_rise", 32'(cmd.cmd_valid), 1);
    chk("cmd_id_offer", 32'(cmd.cmd_id), exp);
    enter_sync = 1'b0;
    ticks(D + 1);
  endtask

  // Scoreboard: every handshake pops the oldest expected id.
  always @(negedge clk) begin
    if (reset === 1'b0 && cmd.cmd_valid === 1'b1 && cmd.cmd_ready === 1'b1) begin
      issued++;
      chk("cmd_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("cmd_id_handshake", 32'(cmd.cmd_id), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int second;

    reset         = 1'b1;
    enter_sync    = 1'b0;
    acoes_sync    = '0;
    cmd.cmd_ready = 1'b0;
    ticks(3);
    chk("rst_cmd_valid", 32'(cmd.cmd_valid), 0);
    chk("rst_cmd_id", 32'(cmd.cmd_id), 0);
    chk("rst_sel_valid", 32'(sel_valid), 0);
    chk("rst_sel_id", 32'(sel_id), 0);
    chk("rst_pending", 32'(pending), 0);
    reset = 1'b0;
    ticks(2);

    // Glitch shorter than the debounce window.
    acoes_sync[2] = 1'b1;
    ticks(3);
    acoes_sync[2] = 1'b0;
    ticks(8);
    chk("glitch_pending", 32'(pending), 0);
    chk("glitch_sel_valid", 32'(sel_valid), 0);

    // Single command with exact latencies.
    acoes_sync[2] = 1'b1;
    ticks(D + 1);
    chk("single_pending", 32'(pending), 32'h04);
    chk("single_sel_early", 32'(sel_valid), 0);
    tick();
    chk("single_sel_valid", 32'(sel_valid), 1);
    chk("single_sel_id", 32'(sel_id), 2);
    exp_q.push_back(acao_id_t'(2));
    enter_sync = 1'b1;
    ticks(D + 1);
    chk("single_cmd_valid", 32'(cmd.cmd_valid), 1);
    chk("single_cmd_id", 32'(cmd.cmd_id), 2);
    chk("single_pending_clr", 32'(pending), 0);
    chk("single_sel_drop", 32'(sel_valid), 0);

    // Backpressure: command held, a second enter press is ignored.
    acoes_sync[2] = 1'b0;
    enter_sync    = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 5) enter_sync = 1'b1;
      chk("bp_cmd_valid", 32'(cmd.cmd_valid), 1);
      chk("bp_cmd_id", 32'(cmd.cmd_id), 2);
      chk("bp_sel_valid", 32'(sel_valid), 0);
    end
    enter_sync = 1'b0;
    ticks(D + 1);
    chk("bp_still_valid", 32'(cmd.cmd_valid), 1);
    cmd.cmd_ready = 1'b1;
    tick();
    chk("hs_cmd_valid_drop", 32'(cmd.cmd_valid), 0);
    chk("hs_issued", 32'(issued), 1);

    // Reset while a command is offered and another request is pending.
    cmd.cmd_ready = 1'b0;
    acoes_sync[0] = 1'b1;
    wait_sel(0);
    acoes_sync[0] = 1'b0;
    confirm(0);
    acoes_sync[5] = 1'b1;
    ticks(D + 1);
    chk("pre_rst_pending", 32'(pending), 32'h20);
    chk("pre_rst_cmd_valid", 32'(cmd.cmd_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cmd_valid", 32'(cmd.cmd_valid), 0);
    chk("async_rst_pending", 32'(pending), 0);
    chk("async_rst_sel_valid", 32'(sel_valid), 0);
    chk("async_rst_cmd_id", 32'(cmd.cmd_id), 0);
    void'(exp_q.pop_front());
    acoes_sync = '0;
    tick();
    reset = 1'b0;
    cmd.cmd_ready = 1'b1;
    ticks(20);
    chk("post_rst_issued", 32'(issued), 1);
    chk("post_rst_sel_valid", 32'(sel_valid), 0);
    chk("post_rst_pending", 32'(pending), 0);

    // Arbitration between simultaneous presses of 1 and 4.
    acoes_sync[1] = 1'b1;
    acoes_sync[4] = 1'b1;
    ticks(D + 1);
    chk("arb_pending", 32'(pending), 32'h12);
    acoes_sync[1] = 1'b0;
    acoes_sync[4] = 1'b0;
    wait_sel(1);
    confirm(1);
    wait_sel(4);
    cmd.cmd_ready = 1'b0;
    confirm(4);
    acoes_sync[1] = 1'b1;
    ticks(D + 1);
    chk("arb_repress_pending", 32'(pending), 32'h02);
    acoes_sync[1] = 1'b0;
    cmd.cmd_ready = 1'b1;
    wait_sel(1);
    confirm(1);

    // Grant order for {0,5} right after 4 has been issued.
    acoes_sync[4] = 1'b1;
    ticks(D + 1);
    acoes_sync[4] = 1'b0;
    wait_sel(4);
    cmd.cmd_ready = 1'b0;
    confirm(4);
    acoes_sync[0] = 1'b1;
    acoes_sync[5] = 1'b1;
    ticks(D + 1);
    chk("rr_pending", 32'(pending), 32'h21);
    acoes_sync = '0;
    cmd.cmd_ready = 1'b1;
`ifdef ROUND_ROBIN_EN
    first  = 5;
    second = 0;
`else
    first  = 0;
    second = 5;
`endif
    wait_sel(first);
    confirm(first);
    wait_sel(second);
    confirm(second);
    ticks(4);
    chk("arb_issued", 32'(issued), 7);

    // Re-press of the selected action coinciding with the enter pulse.
    acoes_sync[3] = 1'b1;
    wait_sel(3);
    acoes_sync[3] = 1'b0;
    ticks(D + 2);
    cmd.cmd_ready = 1'b0;
    chk("coll_sel_valid", 32'(sel_valid), 1);
    exp_q.push_back(acao_id_t'(3));
    acoes_sync[3] = 1'b1;
    enter_sync    = 1'b1;
    ticks(D + 1);
    chk("coll_cmd_valid", 32'(cmd.cmd_valid), 1);
    chk("coll_cmd_id", 32'(cmd.cmd_id), 3);
    chk("coll_pending", 32'(pending), 0);
    acoes_sync = '0;
    enter_sync = 1'b0;
    ticks(D + 1);
    cmd.cmd_ready = 1'b1;
    ticks(15);
    chk("coll_issued", 32'(issued), 8);
    chk("coll_pending_end", 32'(pending), 0);
    chk("coll_sel_end", 32'(sel_valid), 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/action_controller.md
# action_controller

- Turns the six synchronized action buttons and the enter button into a single, confirmed command stream for the processor.
- Each input is debounced and edge-detected; presses are held as pending requests.
- An arbiter picks one pending action and holds it as the current selection until the user confirms it with enter.
- The confirmed action is then issued to the processor core over a valid/ready handshake.
- The block sits between the input synchronizer and the processor's command decoder.

## Interface
Parameters:
- N_ACOES, 6: number of action buttons.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced level changes; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enter_sync  in  1  synchronized enter button, raw level
- acoes_sync  in  [0:N_ACOES-1] x 1  synchronized action buttons, raw levels
- cmd_ready  in  1  processor accepts the command
- cmd_valid  out  1  command offered
- cmd_id  out  $clog2(N_ACOES)  action index of the offered command
- sel_valid  out  1  an action is selected and awaiting enter
- sel_id  out  $clog2(N_ACOES)  selected action index
- pending  out  N_ACOES  pending-request mask; bit i corresponds to acoes_sync[i]

## Operation
- **Debounce, per input (7 instances):**
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever the raw level equals the debounced level.
  - When the raw level has differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips and the counter clears.
  - Press pulse = debounced high AND previous debounced low (one cycle). Releases generate nothing.
- **Pending mask:**
  - An action press pulse sets bit i.
  - The bit clears when that action is confirmed.
  - A press of an already-pending action merges into the existing request.
  - If set and clear hit the same bit in the same cycle, clear wins.
- **FSM states:** IDLE, SELECT, ISSUE.
  - IDLE: if pending≠0, latch grant into sel_id and go to SELECT. Enter presses in IDLE are ignored.
  - SELECT: sel_valid=1. On an enter press pulse: clear pending[sel_id], set cmd_id←sel_id and cmd_valid←1, go to ISSUE. Action presses continue to set pending bits.
  - ISSUE: cmd_valid is held and cmd_id is stable until cmd_valid&&cmd_ready. On that handshake cycle: cmd_valid←0, go to IDLE, and update the arbiter pointer. Enter presses in ISSUE are ignored.
- **Grant:** see Configuration.
- **Reset (asynchronous, any state, including mid-ISSUE):**
  - FSM returns to IDLE.
  - All outputs go to 0: cmd_valid, cmd_id, sel_valid, sel_id, pending.
  - Debounced levels and counters go to 0; the round-robin pointer goes to 0.
  - An offered command is abandoned without a handshake.

## Timing
- Raw action input high from cycle t0 and stable:
  - press pulse in cycle t0+D (D = DEBOUNCE_CYCLES);
  - pending bit visible at t0+D+1;
  - sel_valid visible at t0+D+2 (if the FSM is idle).
- Enter stable high from t1 while in SELECT: press pulse at t1+D; cmd_valid visible at t1+D+1.
- An enter pulse in the same cycle the FSM enters SELECT is not consumed.
- cmd_ready may be held high permanently. The minimum time from cmd_valid rise to next sel_valid rise is 2 cycles (handshake cycle, then IDLE cycle).
- cmd_ready is ignored when cmd_valid=0.

## Configuration
- **ROUND_ROBIN_EN defined:**
  - Grant is the first pending index at or after rr_ptr, searching cyclically.
  - rr_ptr ← (cmd_id+1) mod N_ACOES on each handshake.
- **ROUND_ROBIN_EN undefined:**
  - Grant is the lowest pending index (fixed priority).
  - No pointer register exists.

## Structure
- **Shared package proc_input_pkg:**
  - N_ACOES default constant;
  - acao_id_t (logic [$clog2(N_ACOES)-1:0]);
  - ctrl_state_t enum {IDLE, SELECT, ISSUE}.
- **Sub-module debouncer:** DEBOUNCE_CYCLES parameter; ports clk, reset, raw, level, press.
- The arbiter grant function and the FSM live in action_controller.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Glitch rejection:** acoes_sync[2] high for 3 cycles, then low → pending stays 0, sel_valid stays 0.
- **Single command:**
  - Stimulus: acoes_sync[2] held high.
  - Expected: pending=6'b000100 at t0+5; sel_valid=1 with sel_id=2 at t0+6.
  - Stimulus: enter held high from t1.
  - Expected: cmd_valid=1, cmd_id=2 at t1+5; pending=0.
  - Stimulus: cmd_ready=1.
  - Expected: cmd_valid=0 next cycle.
- **Backpressure:** cmd_ready=0 for 10 cycles → cmd_valid and cmd_id stable throughout; FSM stays in ISSUE; additional enter presses are ignored.
- **Arbitration:**
  - Stimulus: actions 1 and 4 pressed together; three confirm/handshake rounds.
  - With ROUND_ROBIN_EN: issue order is 1, 4.
  - Without ROUND_ROBIN_EN: issue order is 1, 4. Re-pressing 1 during ISSUE of 4 gives next grant 1 in both modes.
  - With ROUND_ROBIN_EN: pending {0,5} after issuing 4 grants 5 first.
- **Reset mid-operation:** reset asserted during ISSUE (cmd_valid=1) → same cycle cmd_valid=0, pending=0, sel_valid=0. After release, with no new presses, no command is issued.
- **Merge/clear collision:** re-press of the selected action whose pulse coincides with the enter pulse → pending bit ends at 0; exactly one command is issued.
